// File: rtl/counter_run_ctrl_if.sv
// Command channel for the run controller: valid/ready handshake carrying an op
// plus the run configuration that START latches.
interface counter_run_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_limit;
    logic [DIV_W-1:0] cmd_div;
    logic             cmd_reload;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_limit,
        output cmd_div,
        output cmd_reload,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_limit,
        input  cmd_div,
        input  cmd_reload,
        output cmd_ready
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller for a WIDTH-bit up-counter: prescaled tick generation, terminal
// count detection, one-shot/auto-reload modes and start/stop/resume/clear commands.
module counter_run_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIV_W  = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    counter_run_ctrl_if.slave cmd,
    output logic              cnt_en,
    output logic [WIDTH-1:0]  count,
    output logic              done,
    output logic              busy,
    output logic [1:0]        state,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_STOP   = 2'b01,
        OP_RESUME = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    state_t           st;
    op_t              op;
    logic [DIV_W-1:0] p;
    logic [DIV_W-1:0] div_q;
    logic [WIDTH-1:0] limit_q;
    logic             reload_q;
    logic             accepted;
    logic             at_limit;

    // No backpressure: every command is taken outside reset.
    assign cmd.cmd_ready = !rst;
    assign accepted      = cmd.cmd_valid && !rst;
    assign op            = op_t'(cmd.cmd_op);

    // A coincident accepted command swallows the tick.
    assign cnt_en   = (st == ST_RUN) && (p == div_q) && !accepted;
    assign at_limit = (count == limit_q);

    assign busy  = (st != ST_IDLE);
    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            count    <= '0;
            p        <= '0;
            limit_q  <= '0;
            div_q    <= '0;
            reload_q <= 1'b0;
            wraps    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accepted) begin
                unique case (op)
                    OP_START: begin
                        limit_q  <= cmd.cmd_limit;
                        div_q    <= cmd.cmd_div;
                        reload_q <= cmd.cmd_reload;
                        count    <= '0;
                        p        <= '0;
                        wraps    <= '0;
                        st       <= ST_RUN;
                    end
                    OP_STOP: begin
                        if (st == ST_RUN) st <= ST_PAUSE;
                    end
                    OP_RESUME: begin
                        if (st == ST_PAUSE) st <= ST_RUN;
                    end
                    OP_CLEAR: begin
                        count <= '0;
                        p     <= '0;
                        wraps <= '0;
                        st    <= ST_IDLE;
                    end
                    default: ;
                endcase
            end else if (st == ST_RUN) begin
                if (cnt_en) begin
                    p <= '0;
                    if (!at_limit) begin
                        count <= count + WIDTH'(1);
                    end else begin
                        done <= 1'b1;
                        // Reload restarts the count; one-shot parks at the limit.
                        if (reload_q) begin
                            count <= '0;
                            if (wraps != {WRAP_W{1'b1}}) wraps <= wraps + WRAP_W'(1);
                        end else begin
                            st <= ST_IDLE;
                        end
                    end
                end else begin
                    p <= p + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: stimulus queues expected snapshots and
// done pulses by cycle; a negedge monitor pops and compares them.
module tb_counter_run_ctrl;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned DIV_W  = 4;
    localparam int unsigned WRAP_W = 8;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cnt_en;
    logic [WIDTH-1:0]  count;
    logic              done;
    logic              busy;
    logic [1:0]        state;
    logic [WRAP_W-1:0] wraps;

    counter_run_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    counter_run_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .WRAP_W(WRAP_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (bus),
        .cnt_en (cnt_en),
        .count  (count),
        .done   (done),
        .busy   (busy),
        .state  (state),
        .wraps  (wraps)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       cyc;
        logic [1:0]        st;
        logic [WIDTH-1:0]  cnt;
        logic [WRAP_W-1:0] wr;
        logic              rdy;
        bit                chk_t;
        int unsigned       ticks;
    } snap_t;

    snap_t       snap_q[$];
    int unsigned done_q[$];
    int unsigned cyc        = 0;
    int unsigned tick_total = 0;
    int unsigned base_ticks = 0;
    int unsigned c0         = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    bit          end_req = 1'b0;
    bit          end_ack = 1'b0;

    // Cycle index: value N is seen between posedge N and posedge N+1.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares whatever the scoreboard expects for the current cycle.
    initial begin
        snap_t s;
        logic  exp_busy;
        bit    bad;
        int    i;
        forever begin
            @(negedge clk);
            if (cnt_en === 1'b1) tick_total++;
            if (done === 1'b1) begin
                vectors++;
                if (done_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: done=1 at cycle %0d, none expected", cyc);
                end else if (done_q[0] != cyc) begin
                    miscompares++;
                    $display("FAIL done_cycle: done at cycle %0d, expected at cycle %0d", cyc, done_q[0]);
                    void'(done_q.pop_front());
                end else begin
                    void'(done_q.pop_front());
                end
            end
            i = 0;
            while (i < snap_q.size()) begin
                if (snap_q[i].cyc == cyc) begin
                    s = snap_q[i];
                    snap_q.delete(i);
                    exp_busy = (s.st != S_IDLE);
                    vectors++;
                    bad = (state !== s.st) || (count !== s.cnt) || (wraps !== s.wr) ||
                          (busy !== exp_busy) || (bus.cmd_ready !== s.rdy) ||
                          (s.chk_t && (tick_total != s.ticks));
                    if (bad) begin
                        miscompares++;
                        $display("FAIL snapshot cyc=%0d: got st=%0d cnt=%0d wraps=%0d busy=%0b rdy=%0b ticks=%0d; want st=%0d cnt=%0d wraps=%0d busy=%0b rdy=%0b ticks=%0d (ticks checked=%0b)",
                                 cyc, state, count, wraps, busy, bus.cmd_ready, tick_total,
                                 s.st, s.cnt, s.wr, exp_busy, s.rdy, s.ticks, s.chk_t);
                    end
                end else begin
                    i++;
                end
            end
            if (end_req && !end_ack) begin
                foreach (snap_q[j]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL snapshot_missed: expectation for cycle %0d never compared (now %0d)", snap_q[j].cyc, cyc);
                end
                foreach (done_q[j]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL done_missing: got no done, expected done at cycle %0d", done_q[j]);
                end
                snap_q.delete();
                done_q.delete();
                end_ack = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle command; c0 becomes the cycle whose edge accepted it.
    task automatic issue(input logic [1:0] op, input int lim, input int dv, input bit rl);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_limit  = WIDTH'(lim);
        bus.cmd_div    = DIV_W'(dv);
        bus.cmd_reload = rl;
        step(1);
        bus.cmd_valid = 1'b0;
        c0         = cyc;
        base_ticks = tick_total;
    endtask

    // Expect values at cycle c0+k; tk >= 0 also checks ticks seen since c0.
    task automatic expect_at(input int k, input logic [1:0] st, input int cnt, input int wr, input int tk);
        snap_t s;
        s.cyc   = c0 + k;
        s.st    = st;
        s.cnt   = WIDTH'(cnt);
        s.wr    = WRAP_W'(wr);
        s.rdy   = 1'b1;
        s.chk_t = (tk >= 0);
        s.ticks = (tk >= 0) ? base_ticks + unsigned'(tk) : 0;
        snap_q.push_back(s);
    endtask

    task automatic expect_now(input logic [1:0] st, input int cnt, input int wr, input logic rdy);
        snap_t s;
        s.cyc   = cyc;
        s.st    = st;
        s.cnt   = WIDTH'(cnt);
        s.wr    = WRAP_W'(wr);
        s.rdy   = rdy;
        s.chk_t = 1'b0;
        s.ticks = 0;
        snap_q.push_back(s);
    endtask

    task automatic expect_done(input int k);
        done_q.push_back(c0 + k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_limit  = '0;
        bus.cmd_div    = '0;
        bus.cmd_reload = 1'b0;
        rst            = 1'b1;

        // Power-on reset
        step(2);
        expect_now(S_IDLE, 0, 0, 1'b0);
        step(1);
        rst = 1'b0;
        expect_now(S_IDLE, 0, 0, 1'b1);
        step(1);

        // Reset in the middle of a run
        issue(OP_START, 9, 2, 1'b0);
        expect_at(9, S_RUN, 3, 0, 3);
        step(10);
        rst = 1'b1;
        step(1);
        expect_now(S_IDLE, 0, 0, 1'b0);
        step(1);
        rst = 1'b0;
        expect_now(S_IDLE, 0, 0, 1'b1);
        step(2);

        // One-shot, limit 3, div 0
        issue(OP_START, 3, 0, 1'b0);
        expect_at(0, S_RUN, 0, 0, 1);
        expect_at(1, S_RUN, 1, 0, 2);
        expect_at(2, S_RUN, 2, 0, 3);
        expect_at(3, S_RUN, 3, 0, 4);
        expect_at(4, S_IDLE, 3, 0, 4);
        expect_at(6, S_IDLE, 3, 0, 4);
        expect_done(4);
        step(8);

        // Auto-reload, limit 15, div 1, 100 cycles
        issue(OP_START, 15, 1, 1'b1);
        expect_at(31, S_RUN, 15, 0, 16);
        expect_at(32, S_RUN, 0, 1, 16);
        expect_at(96, S_RUN, 0, 3, 48);
        expect_at(99, S_RUN, 1, 3, -1);
        expect_done(32);
        expect_done(64);
        expect_done(96);
        step(100);
        issue(OP_CLEAR, 0, 0, 1'b0);
        expect_at(0, S_IDLE, 0, 0, 0);
        step(3);

        // Pause at count 5 / p 2, hold 10 cycles, resume
        issue(OP_START, 9, 3, 1'b0);
        expect_at(22, S_RUN, 5, 0, 5);
        step(22);
        issue(OP_STOP, 0, 0, 1'b0);
        expect_at(0, S_PAUSE, 5, 0, 0);
        expect_at(10, S_PAUSE, 5, 0, 0);
        step(10);
        issue(OP_RESUME, 0, 0, 1'b0);
        expect_at(0, S_RUN, 5, 0, 0);
        expect_at(1, S_RUN, 5, 0, 1);
        expect_at(2, S_RUN, 6, 0, 1);
        expect_at(17, S_RUN, 9, 0, 5);
        expect_at(18, S_IDLE, 9, 0, 5);
        expect_done(18);
        step(22);

        // CLEAR collides with the terminal tick
        issue(OP_START, 2, 0, 1'b0);
        expect_at(2, S_RUN, 2, 0, 2);
        step(2);
        issue(OP_CLEAR, 0, 0, 1'b0);
        expect_at(0, S_IDLE, 0, 0, 0);
        expect_at(3, S_IDLE, 0, 0, 0);
        step(4);

        // START collides with the terminal tick; new limit 7 governs
        issue(OP_START, 2, 0, 1'b0);
        expect_at(2, S_RUN, 2, 0, 2);
        step(2);
        issue(OP_START, 7, 0, 1'b0);
        expect_at(0, S_RUN, 0, 0, 1);
        expect_at(7, S_RUN, 7, 0, 8);
        expect_at(8, S_IDLE, 7, 0, 8);
        expect_done(8);
        step(10);

        // Illegal ops: RESUME in IDLE, STOP in PAUSE
        issue(OP_RESUME, 0, 0, 1'b0);
        expect_at(0, S_IDLE, 7, 0, 0);
        expect_at(2, S_IDLE, 7, 0, 0);
        step(2);
        issue(OP_START, 9, 0, 1'b0);
        expect_at(3, S_RUN, 3, 0, 3);
        step(3);
        issue(OP_STOP, 0, 0, 1'b0);
        expect_at(0, S_PAUSE, 3, 0, 0);
        issue(OP_STOP, 0, 0, 1'b0);
        expect_at(0, S_PAUSE, 3, 0, 0);
        expect_at(2, S_PAUSE, 3, 0, 0);
        step(2);

        // limit 0, div 4: done five cycles after START
        issue(OP_START, 0, 4, 1'b0);
        expect_at(3, S_RUN, 0, 0, 0);
        expect_at(4, S_RUN, 0, 0, 1);
        expect_at(5, S_IDLE, 0, 0, 1);
        expect_done(5);
        step(8);

        // limit 0, div 0, reload: done every cycle, wraps saturates at 255
        issue(OP_START, 0, 0, 1'b1);
        for (int k = 1; k <= 300; k++) expect_done(k);
        expect_at(1, S_RUN, 0, 1, 2);
        expect_at(255, S_RUN, 0, 255, 256);
        expect_at(300, S_RUN, 0, 255, -1);
        step(300);
        issue(OP_CLEAR, 0, 0, 1'b0);
        expect_at(0, S_IDLE, 0, 0, 0);
        expect_at(2, S_IDLE, 0, 0, 0);
        step(5);

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        if (!end_ack) begin
            miscompares++;
            $display("FAIL end_check: scoreboard drain not acknowledged, expected within 3 cycles");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Run controller for the team's WIDTH-bit up-counter datapath. It accepts start, stop, resume and clear commands over a valid/ready handshake, and drives a prescaled count enable. It holds the count register itself, detects the terminal count, and runs in either one-shot or auto-reload mode. It sits between a host/CSR command source and any logic that consumes count ticks or terminal-count events.

Parameters:
WIDTH, 4, count register and limit width
DIV_W, 4, prescaler divisor width
WRAP_W, 8, width of saturating wrap counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts command this cycle
cmd_op  in  2  00 START, 01 STOP, 10 RESUME, 11 CLEAR
cmd_limit  in  WIDTH  terminal count, sampled on START
cmd_div  in  DIV_W  prescale: one tick per (cmd_div+1) cycles, sampled on START
cmd_reload  in  1  1 = auto-reload, 0 = one-shot, sampled on START
cnt_en  out  1  tick: high in cycles where count advances or terminates
count  out  WIDTH  current count
done  out  1  one-cycle pulse on terminal tick
busy  out  1  high in RUN or PAUSE
state  out  2  00 IDLE, 01 RUN, 10 PAUSE
wraps  out  WRAP_W  reload events since START, saturating

Behaviour:
- Reset:
  - Synchronous only, at any clock edge with rst=1, including mid-run.
  - state=IDLE; count, prescaler, limit, div, reload mode, wraps=0; done=0.
  - cmd_ready=0 while rst=1.
- Handshake:
  - cmd_ready = !rst, combinational; no other backpressure.
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - Illegal ops are accepted and ignored (state unchanged): STOP in IDLE/PAUSE, RESUME in IDLE/RUN.
- Prescaler:
  - Internal counter p counts 0..div.
  - cnt_en = (state==RUN) && (p==div) && !cmd_accepted.
  - On cnt_en, p<=0; otherwise in RUN, p<=p+1.
- START (any state):
  - Latches limit, div, reload; count<=0, p<=0, wraps<=0; state<=RUN.
  - Aborts any run in progress; no done pulse.
- RUN tick (cnt_en=1):
  - If count!=limit: count<=count+1.
  - If count==limit: done<=1 next cycle (registered, 1 cycle wide).
    - One-shot: count holds limit, state<=IDLE.
    - Reload: count<=0, wraps<=wraps+1, saturating at all-ones.
- Timing:
  - Period to done is (limit+1)*(div+1) cycles counted from the first RUN cycle.
  - limit=0 is legal: done after div+1 cycles.
- STOP in RUN: state<=PAUSE; count and p frozen.
- RESUME in PAUSE: state<=RUN; count and p continue from their frozen values.
- CLEAR (any state): count<=0, p<=0, wraps<=0, state<=IDLE; no done pulse.
- Simultaneous events:
  - An accepted command takes priority over a coincident tick.
  - That tick is discarded: no count change, no done, cnt_en forced low.
- done:
  - Never asserted in consecutive cycles when div>0.
  - With div=0, limit=0 and reload=1, done is legitimately high every cycle.
- Arithmetic:
  - All counters unsigned.
  - count never exceeds limit; wrap to 0 only via the reload path.

Test Plan:
1. Reset: rst=1 for 2 cycles during an active run (limit=9, div=2).
   -> state=00, count=0, done=0, busy=0, wraps=0, cmd_ready=0 while rst=1; cmd_ready=1 the cycle after rst drops.
2. One-shot: START limit=3, div=0, reload=0.
   -> count 0,1,2,3 on successive cycles; done=1 exactly once on the 5th RUN cycle edge; state=IDLE; count holds 3; cnt_en high for 4 cycles total.
3. Auto-reload: START limit=15, div=1, reload=1, run 100 cycles.
   -> cnt_en every 2nd cycle; count wraps 15->0; done pulse every 32 cycles (3 pulses); wraps=3; busy stays 1.
4. Pause/resume: START limit=9, div=3; STOP when count=5 and p=2; wait 10 cycles; RESUME.
   -> count stays 5 and cnt_en=0 throughout the pause; after resume, count becomes 6 exactly 2 cycles later; done on the expected terminal tick.
5. Collisions:
   - Issue CLEAR in the same cycle as the terminal tick (limit=2, div=0, reload=0) -> no done, count=0, state=IDLE.
   - Repeat with START (limit=7) instead -> no done, count=0, state=RUN, new limit 7 used.
6. Illegal/edge ops:
   - RESUME in IDLE and STOP in PAUSE -> no state or count change.
   - START limit=0, div=4 -> done after exactly 5 cycles, state=IDLE.
